// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO write-port arbiter:
// FSM state encoding and the width helper used to size grant and burst counters.
package fifo_rr_arbiter_pkg;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_GRANT = 1'b1;

    typedef enum logic {
        ST_IDLE  = S_IDLE,
        ST_GRANT = S_GRANT
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin picker: rotates the request vector so the slot after last_grant
// comes first, priority-encodes it, and maps the winner back to a requester index.
module rr_pick #(
    parameter int NUM_IN   = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_IN-1:0]   req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any_req
);

    logic [NUM_IN-1:0]   rot;
    logic [ID_WIDTH-1:0] off;

    // Modulo-NUM_IN step so non-power-of-two sizes never reach an unused index.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int step);
        int s;
        s = (int'(base) + step) % NUM_IN;
        return ID_WIDTH'(s);
    endfunction

    always_comb begin
        rot = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            rot[k] = req[wrap_add(last_grant, k + 1)];
        end
    end

    always_comb begin
        off = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_WIDTH'(k);
            end
        end
    end

    assign idx     = wrap_add(last_grant, int'(off) + 1);
    assign any_req = |req;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// N-to-1 round-robin stream arbiter feeding a single FWFT FIFO write port.
// Grants one requester per burst, registers each accepted beat and tags it with its source.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_TVALID,
    output logic [NUM_IN-1:0]            in_TREADY,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_TDATA,
    output logic                         out_TVALID,
    input  logic                         out_TREADY,
    output logic [DATA_WIDTH-1:0]        out_TDATA,
    output logic [ID_WIDTH-1:0]          out_TID
);

    localparam int CNT_W = clog2_min1(MAX_BURST + 1);
    localparam logic [ID_WIDTH-1:0] LAST_RST  = ID_WIDTH'(NUM_IN - 1);
    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(MAX_BURST - 1);

    generate
        if (ID_WIDTH != clog2_min1(NUM_IN)) begin : g_bad_id_width
            $error("fifo_rr_arbiter: ID_WIDTH must equal clog2(NUM_IN)");
        end
        if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
            $error("fifo_rr_arbiter: NUM_IN must be within 2..16");
        end
        if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_burst
            $error("fifo_rr_arbiter: MAX_BURST must be within 1..256");
        end
    endgenerate

    state_t                  state;
    logic [ID_WIDTH-1:0]     grant;
    logic [ID_WIDTH-1:0]     last_grant;
    logic [CNT_W-1:0]        beat_cnt;
    logic [ID_WIDTH-1:0]     pick_idx;
    logic                    any_req;

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [ID_WIDTH-1:0]     tid_p1;

    logic                    pipe_ready;
    logic                    grant_vld;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic                    xfer;

    rr_pick #(
        .NUM_IN   (NUM_IN),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (in_TVALID),
        .last_grant (last_grant),
        .idx        (pick_idx),
        .any_req    (any_req)
    );

    assign pipe_ready = ~vld_p1 | out_TREADY;
    assign grant_vld  = in_TVALID[grant];
    assign grant_data = in_TDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer       = (state == ST_GRANT) & grant_vld & pipe_ready;

    // Only the granted requester sees ready, and only while the out register can take a beat.
    always_comb begin
        in_TREADY = '0;
        if (state == ST_GRANT) begin
            in_TREADY[grant] = pipe_ready;
        end
    end

    // Stage p0 -> p1: accepted beat into the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            tid_p1  <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= grant_data;
            tid_p1  <= grant;
        end else if (out_TREADY) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= LAST_RST;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end else if (!grant_vld) begin
                        // Requester went quiet: hand the slot back without waiting out the burst.
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_TVALID = vld_p1;
    assign out_TDATA  = data_p1;
    assign out_TID    = tid_p1;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: burst-8 instance for single-source, backpressure,
// early-release and reset cases; burst-2 instance for full contention.
module tb_fifo_rr_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]   vld0, rdy0, vld1, rdy1;
    logic [127:0] tdata0, tdata1;
    logic         ovld0, ordy0, ovld1, ordy1;
    logic [31:0]  odata0, odata1;
    logic [1:0]   otid0, otid1;

    int seq0 [4];
    int seq1 [4];
    logic [33:0] q0 [$];
    logic [33:0] q1 [$];

    int n_chk  = 0;
    int n_fail = 0;

    fifo_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .ID_WIDTH(2), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .in_TVALID(vld0), .in_TREADY(rdy0), .in_TDATA(tdata0),
        .out_TVALID(ovld0), .out_TREADY(ordy0), .out_TDATA(odata0), .out_TID(otid0)
    );

    fifo_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .ID_WIDTH(2), .MAX_BURST(2)) dut_b2 (
        .clk(clk), .reset(reset),
        .in_TVALID(vld1), .in_TREADY(rdy1), .in_TDATA(tdata1),
        .out_TVALID(ovld1), .out_TREADY(ordy1), .out_TDATA(odata1), .out_TID(otid1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester i sends i*256 + (beats already taken from it).
    task automatic drive_data();
        for (int i = 0; i < 4; i++) begin
            tdata0[i*32 +: 32] = 32'(i*256 + seq0[i]);
            tdata1[i*32 +: 32] = 32'(i*256 + seq1[i]);
        end
    endtask

    // Called at a negedge: sample handshakes, cross the posedge, advance producers.
    task automatic cycle();
        logic [3:0] take0, take1;
        #1;
        take0 = vld0 & rdy0;
        take1 = vld1 & rdy1;
        if (ovld0 && ordy0) q0.push_back({otid0, odata0});
        if (ovld1 && ordy1) q1.push_back({otid1, odata1});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (take0[i]) seq0[i]++;
            if (take1[i]) seq1[i]++;
        end
        drive_data();
        @(negedge clk);
    endtask

    logic [3:0]  vtab [18] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000,
                               4'b1000, 4'b0111, 4'b0111, 4'b0111, 4'b0110, 4'b0110,
                               4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0]  rtab [18] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                               4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                               4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    logic [33:0] etab [7]  = '{{2'd2, 32'h200}, {2'd2, 32'h201}, {2'd2, 32'h202},
                               {2'd3, 32'h300}, {2'd0, 32'h018}, {2'd1, 32'h100},
                               {2'd2, 32'h203}};

    initial begin
        reset = 1'b1;
        vld0 = '0; vld1 = '0; ordy0 = 1'b1; ordy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq0[i] = 0;
            seq1[i] = 0;
        end
        drive_data();
        repeat (2) @(posedge clk);
        @(negedge clk);

        check("rst_out_vld",  ovld0,  1'b0);
        check("rst_out_data", odata0, 32'd0);
        check("rst_out_tid",  otid0,  2'd0);
        check("rst_in_rdy",   rdy0,   4'b0000);
        check("rst_b2_vld",   ovld1,  1'b0);
        reset = 1'b0;

        // Single requester, burst 8: ready low on the two arbitration cycles only.
        vld0 = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            #1;
            check("single_rdy", rdy0[0], (i == 0 || i == 9) ? 1'b0 : 1'b1);
            cycle();
        end
        vld0 = 4'b0000;
        cycle();
        cycle();
        check("single_count", q0.size(), 16);
        for (int j = 0; j < 16 && j < q0.size(); j++) begin
            check("single_beat", q0[j], {2'd0, 32'(j)});
        end

        // Full contention, burst 2: eight grants of two beats each.
        vld1 = 4'b1111;
        repeat (24) cycle();
        vld1 = 4'b0000;
        cycle();
        cycle();
        check("contend_count", q1.size(), 16);
        for (int j = 0; j < 16 && j < q1.size(); j++) begin
            int r, s;
            r = (j / 2) % 4;
            s = (j % 2) + 2 * (j / 8);
            check("contend_beat", q1[j], {2'(r), 32'(r*256 + s)});
        end

        // Backpressure three beats into a burst.
        q0.delete();
        vld0 = 4'b0001;
        repeat (4) cycle();
        ordy0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rdy",  rdy0[0], 1'b0);
            check("stall_vld",  ovld0,   1'b1);
            check("stall_data", odata0,  32'd18);
            cycle();
        end
        ordy0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("resume_rdy", rdy0[0], (i < 5) ? 1'b1 : 1'b0);
            cycle();
        end
        vld0 = 4'b0000;
        cycle();
        cycle();
        check("stall_count", q0.size(), 8);
        for (int j = 0; j < 8 && j < q0.size(); j++) begin
            check("stall_beat", q0[j], {2'd0, 32'(16 + j)});
        end

        // Early release and rotating priority.
        q0.delete();
        for (int e = 0; e < 18; e++) begin
            vld0 = vtab[e];
            #1;
            check("release_rdy", rdy0, rtab[e]);
            cycle();
        end
        check("release_count", q0.size(), 7);
        for (int j = 0; j < 7 && j < q0.size(); j++) begin
            check("release_beat", q0[j], etab[j]);
        end

        // Asynchronous reset with a beat held in the output register.
        vld0 = 4'b1111;
        repeat (3) cycle();
        check("pre_rst_vld", ovld0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_vld", ovld0, 1'b0);
        check("async_rst_rdy", rdy0,  4'b0000);
        check("async_rst_data", odata0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        cycle();
        #1;
        check("post_rst_rdy", rdy0, 4'b0001);
        cycle();
        cycle();
        check("post_rst_count", q0.size(), 1);
        if (q0.size() > 0) begin
            check("post_rst_beat", q0[0], {2'd0, 32'd25});
        end
        vld0 = 4'b0000;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin N-to-1 stream arbiter that shares one FWFT FIFO write port (din_TVALID/din_TREADY/din_TDATA) between NUM_IN producer kernels.
- Grants one requester at a time for a bounded burst, registers the selected beat, and tags it with the source index.
- Sits directly upstream of the FIFO wrapper. out_* connects to the FIFO din_* ports; out_TID travels alongside or is dropped.

Parameters:
- NUM_IN, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per requester.
- ID_WIDTH, 2, width of out_TID; must equal clog2(NUM_IN), minimum 1.
- MAX_BURST, 8, maximum beats accepted per grant before forced re-arbitration (1..256).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_TVALID  in  NUM_IN  per-requester valid.
- in_TREADY  out  NUM_IN  per-requester ready; combinational from state and out register.
- in_TDATA  in  NUM_IN*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_TVALID  out  1  registered output valid (to FIFO din_TVALID).
- out_TREADY  in  1  downstream ready (from FIFO din_TREADY, i.e. full_n).
- out_TDATA  out  DATA_WIDTH  registered output data.
- out_TID  out  ID_WIDTH  index of the requester that produced the current out beat.

Behaviour:
- Reset values (asynchronous):
  - out_TVALID=0, out_TDATA=0, out_TID=0.
  - state=IDLE, grant=0, beat_cnt=0.
  - last_grant=NUM_IN-1, so requester 0 has first priority.
- Output register:
  - pipe_ready = ~out_TVALID | out_TREADY.
  - On an accepted input beat: load out_TDATA/out_TID and set out_TVALID=1.
  - Else if out_TREADY is high: clear out_TVALID.
  - out_TDATA holds its value while out_TVALID=1 and out_TREADY=0.
- FSM:
  - IDLE:
    - in_TREADY=all zeros.
    - If any in_TVALID: pick the first asserted index scanning last_grant+1, last_grant+2, ... modulo NUM_IN.
    - Load grant with that index, beat_cnt=0, go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT:
    - in_TREADY[grant]=pipe_ready; all other bits 0.
    - Transfer = in_TVALID[grant] & in_TREADY[grant]; on transfer, beat_cnt increments.
    - Transfer with beat_cnt==MAX_BURST-1: last_grant<=grant, go to IDLE.
    - in_TVALID[grant]==0: last_grant<=grant, go to IDLE (grant released, no beat taken).
    - Valid high with pipe_ready low: stay in GRANT, beat_cnt unchanged.
- Latency:
  - Input accept to out_TVALID is 1 cycle.
  - Each grant costs one IDLE arbitration cycle, so a sustained single requester gets MAX_BURST beats, then 1 bubble.
- Fairness: a requester that was just granted has the lowest priority at the next arbitration. No requester waits more than NUM_IN-1 grants.
- Boundary conditions:
  - MAX_BURST=1: every beat re-arbitrates (alternating GRANT/IDLE).
  - NUM_IN not a power of two: the modulo wrap skips nonexistent indices.
  - Requester deasserts valid mid-burst: release immediately with no penalty beyond the IDLE cycle.
  - Downstream full (out_TREADY=0 with out_TVALID=1): in_TREADY=0, grant held, no data loss.
  - Reset mid-burst: the registered beat is discarded, out_TVALID drops asynchronously, arbitration restarts at requester 0.
- Widths: beat_cnt is clog2(MAX_BURST+1) bits; last_grant and grant are ID_WIDTH bits.

Decomposition:
- Shared package holds:
  - state encoding localparams (S_IDLE=0, S_GRANT=1);
  - a clog2-based width helper used for ID_WIDTH and beat_cnt checks.
- One natural sub-module, rr_pick: combinational rotate, priority-encode, un-rotate. Inputs are req[NUM_IN] and last_grant. Outputs are idx and any_req.
- The FSM, counter and output register stay in fifo_rr_arbiter.

Test Plan:
- Single requester: in_TVALID=0001 continuously, out_TREADY=1, MAX_BURST=8, data 0..15. Required: out_TID=0, data 0..15 in order, one bubble after the 8th beat, 16 beats in 18 accepting cycles.
- Full contention: in_TVALID=1111, out_TREADY=1, MAX_BURST=2. Required: out_TID sequence 0,0,1,1,2,2,3,3,0,0…, no source beat dropped or duplicated.
- Backpressure: hold out_TREADY=0 for 5 cycles mid-burst. Required:
  - out_TVALID and out_TDATA stable;
  - in_TREADY[grant]=0;
  - beat_cnt frozen;
  - on release the burst resumes and completes exactly MAX_BURST beats.
- Early release: requester 2 drops valid after 3 of 8 beats while requester 3 is valid. Required: the next grant goes to 3, and 2 loses priority until 3, 0 and 1 have been considered.
- Async reset mid-burst: assert reset between clock edges with out_TVALID=1. Required:
  - out_TVALID=0 immediately;
  - in_TREADY=0;
  - after reset release with in_TVALID=1111, first out_TID=0.
